bitrev_reorder_buf: RTL and testbench
=====================================

Name: bitrev_reorder_buf

Overview:
Streaming bit-reversal reorder buffer for the radix-2 FFT datapath. It accepts frames of 2**LOG2N samples in natural order and emits each frame in bit-reversed index order. Two ping-pong banks let frame k+1 be written while frame k is read. It replaces the fixed-width combinational index reverser at the FFT input/output boundary.

Parameters:
LOG2N, 3, log2 of frame length (N = 2**LOG2N); legal range 1..10
DW, 16, sample width in bits (packed re/im is the caller's choice)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  buffer can accept a sample
in_data  in  DW  input sample, natural order
out_valid  out  1  output register holds a sample
out_ready  in  1  downstream accepts a sample
out_data  out  DW  output sample, bit-reversed order
out_idx  out  LOG2N  natural index of out_data, for example bitrev(read count)
out_last  out  1  high with the final sample of a frame

Behaviour:
- Reset (async assert, sync release): in_ready=1 on first edge after release (0 while rst_n low), out_valid=0, out_last=0, out_idx=0, out_data=0; wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, full[1:0]=0. Memory contents are not reset.
- Write side: in_ready = !full[wr_bank]. Transfer occurs when in_valid && in_ready.
  - Each transfer writes mem[wr_bank][wr_cnt] and increments wr_cnt (mod N).
  - When wr_cnt==N-1 transfers: full[wr_bank] is set, wr_bank toggles, and wr_cnt wraps to 0.
- Read side FSM:
  - IDLE -> STREAM when full[rd_bank]==1.
  - In STREAM, the output register loads when !out_valid || out_ready. It loads mem[rd_bank][bitrev(rd_cnt)], sets out_idx=bitrev(rd_cnt), sets out_last=(rd_cnt==N-1), and increments rd_cnt.
  - On loading rd_cnt==N-1: full[rd_bank] clears, rd_bank toggles, rd_cnt=0. The FSM returns to IDLE unless full[new rd_bank] is already 1, in which case it stays in STREAM with no bubble.
  - If no load occurs and out_ready is high, out_valid drops to 0.
- Latency: out_valid rises on the 1st edge after the edge that accepts sample N-1 of a frame, provided the previous frame has drained.
- Throughput: 1 sample/clk sustained on both sides. Frame boundaries add no bubble.
- Output holds stable (data/idx/last) while out_valid && !out_ready.
- Both banks full: in_ready=0 until the read side clears a bank.
- A bank clear and a bank set in the same cycle on different banks are both honoured. in_ready reflects the registered full flags, so there is no combinational path from out_ready to in_ready.
- Reset mid-frame: the partial frame and any buffered frames are discarded, and all counters and flags return to their reset values.
- bitrev(x): bit i of the result = bit LOG2N-1-i of x.

Optional Feature:
BITREV_BYPASS_EN. Defined: adds input port bypass (1 bit).
- bypass is sampled when the FSM enters STREAM for a frame (IDLE->STREAM or at the frame wrap) and is held for that whole frame.
- While held high, the frame reads in natural order: address rd_cnt, out_idx=rd_cnt.
- Not defined: no port is added, and output is always bit-reversed.

Test Plan:
- LOG2N=3, DW=16, out_ready=1; send 0..7 -> out_data 0,4,2,6,1,5,3,7; out_idx identical; out_last only with 7; out_valid 1 cycle after the 8th accept.
- Back-to-back: send 0..15 continuously with in_valid=1 -> in_ready stays 1; output 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15 with no gap between frames.
- Backpressure: out_ready=0, stream 0..15 -> in_ready falls after the 16th accept; hold 5 cycles with out_data=0 stable; raise out_ready -> correct order, in_ready returns 1 cycle after frame 0 drains.
- Random out_ready (50%), 4 frames of random data -> scoreboard matches bit-reversed order; no loss or duplication.
- Reset pulse after 5 samples of a frame -> all outputs 0; a fresh frame 100..107 then yields 100,104,102,106,101,105,103,107.
- BITREV_BYPASS_EN with bypass=1 for frame 0 and 0 for frame 1, inputs 0..15 -> 0..7 in natural order, then 8,12,10,14,9,13,11,15.

Source files
------------

// File: rtl/bitrev_reorder_buf_if.sv
// Handshake bundle for the bit-reversal reorder buffer: natural-order input
// stream and bit-reversed output stream, both valid/ready.
interface bitrev_reorder_buf_if #(
    parameter int LOG2N = 3,
    parameter int DW    = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [LOG2N-1:0] out_idx;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/bitrev_reorder_buf.sv
// Ping-pong bit-reversal reorder buffer: frames of 2**LOG2N samples in, same frame out in
// bit-reversed index order. Optional BITREV_BYPASS_EN adds a per-frame natural-order bypass.
module bitrev_reorder_buf #(
    parameter int LOG2N = 3,
    parameter int DW    = 16
) (
    input  logic clk,
    input  logic rst_n,
`ifdef BITREV_BYPASS_EN
    input  logic bypass,
`endif
    bitrev_reorder_buf_if.slave bus
);
    localparam int N = 1 << LOG2N;

    typedef logic [LOG2N-1:0] idx_t;
    typedef enum logic {S_IDLE, S_STREAM} state_t;

    function automatic idx_t bitrev(input idx_t x);
        idx_t r;
        for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
        return r;
    endfunction

    logic [DW-1:0] mem [0:2*N-1];

    state_t        state;
    idx_t          wr_cnt, rd_cnt;
    logic          wr_bank, rd_bank;
    logic [1:0]    full, full_nxt;
    logic          rdy_en;
    logic          out_valid_p0, out_last_p0;
    logic [DW-1:0] out_data_p0;
    idx_t          out_idx_p0;

    logic          wr_fire, wr_wrap;
    logic          load, rd_wrap, natural_rd;
    logic          nxt_rd_bank;
    idx_t          rd_addr;

    assign bus.in_ready  = rdy_en && !full[wr_bank];
    assign bus.out_valid = out_valid_p0;
    assign bus.out_data  = out_data_p0;
    assign bus.out_idx   = out_idx_p0;
    assign bus.out_last  = out_last_p0;

    assign wr_fire = bus.in_valid && bus.in_ready;
    assign wr_wrap = wr_fire && (wr_cnt == idx_t'(N-1));

    // The first sample of a frame is loaded straight out of IDLE so the
    // output appears one edge after the frame completes.
    assign load = (!out_valid_p0 || bus.out_ready) &&
                  ((state == S_STREAM) || full[rd_bank]);
    assign rd_wrap     = load && (rd_cnt == idx_t'(N-1));
    assign nxt_rd_bank = ~rd_bank;

`ifdef BITREV_BYPASS_EN
    logic bypass_q;
    assign natural_rd = (state == S_IDLE) ? bypass : bypass_q;
`else
    assign natural_rd = 1'b0;
`endif

    assign rd_addr = natural_rd ? rd_cnt : bitrev(rd_cnt);

    // Set and clear always target different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (rd_wrap) full_nxt[rd_bank] = 1'b0;
        if (wr_wrap) full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wr_bank, wr_cnt}] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            full         <= 2'b00;
            rdy_en       <= 1'b0;
            out_valid_p0 <= 1'b0;
            out_last_p0  <= 1'b0;
            out_idx_p0   <= '0;
            out_data_p0  <= '0;
`ifdef BITREV_BYPASS_EN
            bypass_q     <= 1'b0;
`endif
        end else begin
            rdy_en <= 1'b1;
            full   <= full_nxt;

            // write stage
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_wrap) wr_bank <= ~wr_bank;
            end

            // read stage -> output register
            if (load) begin
                out_valid_p0 <= 1'b1;
                out_data_p0  <= mem[{rd_bank, rd_addr}];
                out_idx_p0   <= rd_addr;
                out_last_p0  <= (rd_cnt == idx_t'(N-1));
                rd_cnt       <= rd_cnt + 1'b1;
                if (rd_wrap) begin
                    rd_bank <= nxt_rd_bank;
                    state   <= full[nxt_rd_bank] ? S_STREAM : S_IDLE;
`ifdef BITREV_BYPASS_EN
                    bypass_q <= bypass;
`endif
                end else begin
                    state <= S_STREAM;
`ifdef BITREV_BYPASS_EN
                    if (state == S_IDLE) bypass_q <= bypass;
`endif
                end
            end else if (bus.out_ready) begin
                out_valid_p0 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Directed bench for bitrev_reorder_buf (LOG2N=3, DW=16); define BITREV_BYPASS_EN to
// also exercise the natural-order bypass.
module tb_bitrev_reorder_buf;
    localparam int LOG2N = 3;
    localparam int DW    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef BITREV_BYPASS_EN
    logic bypass = 1'b0;
`endif
    always #5 clk = ~clk;

    bitrev_reorder_buf_if #(.LOG2N(LOG2N), .DW(DW)) bus ();

    bitrev_reorder_buf #(.LOG2N(LOG2N), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef BITREV_BYPASS_EN
        .bypass(bypass),
`endif
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [DW-1:0] src [$];
    int            outq [$];
    int            idxq [$];
    int            lastq [$];
    int            cycq [$];
    logic [DW-1:0] rdat [32];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            outq.push_back(int'(bus.out_data));
            idxq.push_back(int'(bus.out_idx));
            lastq.push_back(int'(bus.out_last));
            cycq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        outq.delete(); idxq.delete(); lastq.delete(); cycq.delete(); src.delete();
    endtask

    task automatic send_src(output int stalls);
        int i;
        int guard;
        logic acc;
        i = 0; guard = 0; stalls = 0;
        while (i < src.size() && guard < 2000) begin
            bus.in_valid = 1'b1;
            bus.in_data  = src[i];
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) i++; else stalls++;
            guard++;
        end
        bus.in_valid = 1'b0;
        check("send_done", i, src.size());
    endtask

    task automatic wait_out(input int n);
        int guard;
        guard = 0;
        while (outq.size() < n && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("out_count", outq.size(), n);
    endtask

    initial begin
        int stalls;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // reset state
        #3;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", bus.in_ready, 1);

        // single frame, latency and order
        clr();
        for (int i = 0; i < 8; i++) src.push_back(DW'(i));
        send_src(stalls);
        check("t1_valid_before", bus.out_valid, 0);
        @(posedge clk); #1;
        check("t1_valid_after", bus.out_valid, 1);
        check("t1_first_data", bus.out_data, 0);
        wait_out(8);
        for (int j = 0; j < 8; j++) begin
            check("t1_data", outq[j], br[j]);
            check("t1_idx", idxq[j], br[j]);
            check("t1_last", lastq[j], (j == 7) ? 1 : 0);
        end

        // back-to-back frames
        clr();
        for (int i = 0; i < 16; i++) src.push_back(DW'(i));
        send_src(stalls);
        check("t2_stalls", stalls, 0);
        wait_out(16);
        for (int j = 0; j < 16; j++) begin
            check("t2_data", outq[j], (j / 8) * 8 + br[j % 8]);
            check("t2_last", lastq[j], (j % 8 == 7) ? 1 : 0);
            if (j < 15) check("t2_gap", cycq[j+1] - cycq[j], 1);
        end

        // backpressure with both banks full
        clr();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) src.push_back(DW'(i));
        send_src(stalls);
        check("t3_stalls", stalls, 0);
        check("t3_in_ready_full", bus.in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("t3_hold_valid", bus.out_valid, 1);
            check("t3_hold_data", bus.out_data, 0);
            check("t3_hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            check("t3_in_ready_ret", bus.in_ready, (k == 7) ? 1 : 0);
        end
        wait_out(16);
        for (int j = 0; j < 16; j++)
            check("t3_data", outq[j], (j / 8) * 8 + br[j % 8]);

        // random backpressure, 4 frames
        clr();
        for (int i = 0; i < 32; i++) begin
            rdat[i] = DW'($urandom_range(0, 65535));
            src.push_back(rdat[i]);
        end
        fork
            send_src(stalls);
            begin
                for (int k = 0; k < 120; k++) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 1) == 1);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_out(32);
        for (int j = 0; j < 32; j++)
            check("t4_data", outq[j], rdat[(j / 8) * 8 + br[j % 8]]);

        // reset mid-frame
        clr();
        for (int i = 0; i < 5; i++) src.push_back(DW'(50 + i));
        send_src(stalls);
        rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready", bus.in_ready, 0);
        check("t5_rst_valid", bus.out_valid, 0);
        check("t5_rst_data", bus.out_data, 0);
        check("t5_rst_idx", bus.out_idx, 0);
        check("t5_rst_last", bus.out_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clr();
        for (int i = 0; i < 8; i++) src.push_back(DW'(100 + i));
        send_src(stalls);
        wait_out(8);
        for (int j = 0; j < 8; j++)
            check("t5_data", outq[j], 100 + br[j]);

`ifdef BITREV_BYPASS_EN
        // bypass on frame 0, bit-reversed on frame 1
        clr();
        bypass = 1'b1;
        for (int i = 0; i < 16; i++) src.push_back(DW'(i));
        fork
            send_src(stalls);
            begin
                repeat (12) @(posedge clk);
                #1;
                bypass = 1'b0;
            end
        join
        wait_out(16);
        for (int j = 0; j < 16; j++) begin
            check("t6_data", outq[j], (j < 8) ? j : 8 + br[j % 8]);
            check("t6_idx", idxq[j], (j < 8) ? j : br[j % 8]);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
